modred_pipe: RTL and testbench

- Pipelined, parametrised Barrett modular reducer. Computes s = a mod Q for a 2*LOGQ-bit product.
- Successor to the combinational modred. Adds a 3-stage registered datapath, valid/ready handshaking on both sides, back-pressure and a passthrough tag.
- Sits between the butterfly multiplier and the NTT coefficient write-back path.

---
 rtl/modred_pkg.sv | 24 ++
 rtl/modred_pipe_stage.sv | 53 +++++
 rtl/modred_pipe.sv | 118 +++++++++++
 tb/tb_modred_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/modred_pkg.sv
// modred_pkg: shared constants and helpers for the Barrett modular reducer.
//   LOGQ_DEF / Q_DEF : default modulus width and modulus.
//   barrett_m()      : Barrett constant M = floor(2^(2*logq) / q).
//   red_width()      : width of the partially reduced value r (logq+1).
//   mod_ref()        : plain a % q reference model for benches.
package modred_pkg;

  localparam int              LOGQ_DEF = 17;
  localparam longint unsigned Q_DEF    = 64'd65537;

  function automatic logic [127:0] barrett_m(input int logq, input longint unsigned q);
    return (128'd1 << (2 * logq)) / {64'd0, q};
  endfunction

  function automatic int red_width(input int logq);
    return logq + 1;
  endfunction

  function automatic longint unsigned mod_ref(input longint unsigned a,
                                              input longint unsigned q = Q_DEF);
    return a % q;
  endfunction

endpackage

// File: rtl/modred_pipe_stage.sv
// modred_pipe_stage: one valid/ready register slice carrying data plus tag.
//   valid_i/ready_o/data_i/tag_i : upstream side (ready_o = slice free).
//   valid_o/ready_i/data_o/tag_o : downstream side (ready_i = next slice free).
// The slice loads whenever it is free, so an empty slice always accepts and
// a full slice that drains can take new data in the same cycle.
// RST_DATA=1 also clears data/tag on reset (used for the output slice).
module modred_pipe_stage #(
  parameter int DW       = 8,
  parameter int TW       = 1,
  parameter bit RST_DATA = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [DW-1:0] data_i,
  input  logic [TW-1:0] tag_i,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic [TW-1:0] tag_o
);

  logic          v_q, v_d;
  logic [DW-1:0] data_q;
  logic [TW-1:0] tag_q;
  logic          load;

  assign ready_o = !v_q || ready_i;
  assign v_d     = ready_o ? valid_i : v_q;
  assign load    = ready_o && valid_i;

  always_ff @(posedge clk) begin
    if (!rst_n) v_q <= 1'b0;
    else        v_q <= v_d;
  end

  // A stalled slice keeps data/tag untouched; only a real load overwrites.
  always_ff @(posedge clk) begin
    if (RST_DATA && !rst_n) begin
      data_q <= '0;
      tag_q  <= '0;
    end else if (load) begin
      data_q <= data_i;
      tag_q  <= tag_i;
    end
  end

  assign valid_o = v_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/modred_pipe.sv
// modred_pipe: 3-stage pipelined Barrett reducer, out_s = in_a mod Q.
//   clk, rst_n (sync, active low)
//   in_valid/in_ready/in_a/in_tag    : operand input handshake
//   out_valid/out_ready/out_s/out_tag: result output handshake
//   busy                              : any stage holds data
// S1 registers a and the Barrett quotient estimate qh = (a*M) >> 2*LOGQ,
// S2 registers r = a - qh*Q (0 <= r < 2Q), S3 registers the final
// conditional subtraction and drives the outputs directly.
module modred_pipe
  import modred_pkg::*;
#(
  parameter int              LOGQ = LOGQ_DEF,
  parameter longint unsigned Q    = Q_DEF,
  parameter int              TAGW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*LOGQ-1:0] in_a,
  input  logic [TAGW-1:0]   in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LOGQ-1:0]   out_s,
  output logic [TAGW-1:0]   out_tag,
  output logic              busy
);

  localparam int AW  = 2 * LOGQ;       // operand width
  localparam int MW  = AW + 1;         // Barrett constant width
  localparam int PW  = 4 * LOGQ + 1;   // full a*M product width
  localparam int QHW = PW - AW;        // quotient estimate width
  localparam int RW  = red_width(LOGQ);

  localparam logic [MW-1:0]  M   = MW'(barrett_m(LOGQ, Q));
  localparam logic [QHW-1:0] QQH = QHW'(Q);
  localparam logic [RW-1:0]  QR  = RW'(Q);
  localparam logic [RW-1:0]  Q2  = RW'(2 * Q);

  // ---- S1: a and the high part of p = a*M (the fraction bits of p are
  // never used downstream, so only the quotient part is stored).
  logic [QHW-1:0]    qh_d;
  logic              s1_v, s1_rdy;
  logic [AW-1:0]     s1_a;
  logic [QHW-1:0]    s1_qh;
  logic [TAGW-1:0]   s1_tag;

  assign qh_d = QHW'((PW'(in_a) * PW'(M)) >> AW);

  // ---- S2: r = a - qh*Q; qh underestimates by at most 1, so r < 2Q and
  // fits in LOGQ+1 bits.
  logic [AW-1:0]     qq;
  logic [RW-1:0]     r_d;
  logic              s2_v, s2_rdy;
  logic [RW-1:0]     s2_r;
  logic [TAGW-1:0]   s2_tag;

  assign qq  = AW'(s1_qh * QQH);
  assign r_d = RW'(s1_a - qq);

  // ---- S3: final correction into [0, Q).
  logic [LOGQ-1:0]   s_d;
  logic              s3_rdy;

  assign s_d = (s2_r >= QR) ? LOGQ'(s2_r - QR) : LOGQ'(s2_r);

  modred_pipe_stage #(.DW(AW + QHW), .TW(TAGW), .RST_DATA(1'b0)) u_s1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(in_valid),
    .ready_o(s1_rdy),
    .data_i ({in_a, qh_d}),
    .tag_i  (in_tag),
    .valid_o(s1_v),
    .ready_i(s2_rdy),
    .data_o ({s1_a, s1_qh}),
    .tag_o  (s1_tag)
  );

  modred_pipe_stage #(.DW(RW), .TW(TAGW), .RST_DATA(1'b0)) u_s2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(s1_v),
    .ready_o(s2_rdy),
    .data_i (r_d),
    .tag_i  (s1_tag),
    .valid_o(s2_v),
    .ready_i(s3_rdy),
    .data_o (s2_r),
    .tag_o  (s2_tag)
  );

  modred_pipe_stage #(.DW(LOGQ), .TW(TAGW), .RST_DATA(1'b1)) u_s3 (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid_i(s2_v),
    .ready_o(s3_rdy),
    .data_i (s_d),
    .tag_i  (s2_tag),
    .valid_o(out_valid),
    .ready_i(out_ready),
    .data_o (out_s),
    .tag_o  (out_tag)
  );

  assign in_ready = s1_rdy;
  assign busy     = s1_v | s2_v | out_valid;

`ifndef SYNTHESIS
  // A partial remainder of 2Q or more means the Barrett bound was broken
  // (bad Q/LOGQ pairing); the single correction step would then be wrong.
  always_ff @(posedge clk) begin
    if (rst_n && s2_v)
      assert (s2_r < Q2) else $error("modred_pipe: partial remainder %0d >= 2Q", s2_r);
  end
`endif

endmodule

// File: tb/tb_modred_pipe.sv
// Bench for modred_pipe (LOGQ=17, Q=65537, TAGW=4): directed vector table,
// streaming, back-pressure, random stall and mid-flight reset sequences.
module tb_modred_pipe;
  import modred_pkg::*;

  localparam int LOGQ = 17;
  localparam int TAGW = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [2*LOGQ-1:0] in_a;
  logic [TAGW-1:0]   in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [LOGQ-1:0]   out_s;
  logic [TAGW-1:0]   out_tag;
  logic              busy;

  modred_pipe #(.LOGQ(LOGQ), .Q(64'd65537), .TAGW(TAGW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_s    (out_s),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*LOGQ-1:0] a;
    logic [TAGW-1:0]   tag;
    logic [LOGQ-1:0]   exp;
  } vec_t;

  typedef struct {
    logic [LOGQ-1:0] s;
    logic [TAGW-1:0] tag;
  } sb_t;

  vec_t vt[11];
  sb_t  sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  // One clock cycle, entered and left at a negedge. Inputs are applied, and
  // after they settle the transfers that happen on the next posedge are
  // recorded (input -> push expectation, output -> pop and compare).
  logic last_ir;
  task automatic cyc(input bit iv, input logic [2*LOGQ-1:0] a, input logic [TAGW-1:0] t,
                     input bit ordy, output bit acc);
    sb_t e;
    in_valid  = iv;
    in_a      = a;
    in_tag    = t;
    out_ready = ordy;
    #1;
    last_ir = in_ready;
    acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("sb_s", out_s, e.s);
        chk("sb_tag", out_tag, e.tag);
      end
    end
    if (acc) sbq.push_back('{LOGQ'(mod_ref(64'(a))), t});
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    bit acc;
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      cyc(1'b0, '0, '0, 1'b1, acc);
      n++;
    end
    chk(nm, sbq.size(), 0);
  endtask

  // Single operand with out_ready=1: check exact latency, value and tag.
  task automatic run_single(input string nm, input logic [2*LOGQ-1:0] a,
                            input logic [TAGW-1:0] t, input logic [LOGQ-1:0] exp);
    int lat = 0;
    logic [LOGQ-1:0] gs = '0;
    logic [TAGW-1:0] gt = '0;
    in_valid  = 1'b1;
    in_a      = a;
    in_tag    = t;
    out_ready = 1'b1;
    #1;
    chk({nm, "_ready"}, in_ready, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      #1;
      if (out_valid && lat == 0) begin
        lat = k;
        gs  = out_s;
        gt  = out_tag;
      end
    end
    @(negedge clk);
    chk({nm, "_lat"}, lat, 3);
    chk({nm, "_s"}, gs, exp);
    chk({nm, "_tag"}, gt, t);
  endtask

  initial begin
    bit acc;
    int nacc, notrdy, sent, cycles;
    logic [LOGQ-1:0] hold_s;
    logic [TAGW-1:0] hold_t;
    logic [TAGW-1:0] tg;
    logic [2*LOGQ-1:0] ra;

    vt[0]  = '{34'd2,            4'd1,  17'd2};
    vt[1]  = '{34'd65537,        4'd2,  17'd0};
    vt[2]  = '{34'd65536,        4'd3,  17'd65536};
    vt[3]  = '{34'h1_0000_0000,  4'd4,  17'd1};
    vt[4]  = '{34'h3_FFFF_FFFF,  4'd5,  17'd3};
    vt[5]  = '{34'h1_0000_0005,  4'd6,  17'd6};
    vt[6]  = '{34'd0,            4'd7,  17'd0};
    vt[7]  = '{34'd131074,       4'd8,  17'd0};
    vt[8]  = '{34'd131072,       4'd9,  17'd65535};
    vt[9]  = '{34'd131073,       4'd10, 17'd65536};
    vt[10] = '{34'd1000000,      4'd15, 17'd16945};

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_s", out_s, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 11; i++) run_single($sformatf("vec%0d", i), vt[i].a, vt[i].tag, vt[i].exp);

    // Back-pressure: 5 cycles of feeding with out_ready=0
    nacc = 0;
    hold_s = '0; hold_t = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 34'(100000 * (i + 1) + 17), 4'(i + 1), 1'b0, acc);
      if (acc) nacc++;
      if (i == 3) begin hold_s = out_s; hold_t = out_tag; end
      if (i == 4) begin
        chk("bp_stable_s", out_s, hold_s);
        chk("bp_stable_tag", out_tag, hold_t);
        chk("bp_in_ready", last_ir, 0);
      end
    end
    chk("bp_accepted", nacc, 3);
    drain("bp_drain");

    // Streaming: 1000 back-to-back, tags cycling
    notrdy = 0;
    tg = '0;
    for (int i = 0; i < 1000; i++) begin
      ra = {2'($urandom), 32'($urandom)};
      cyc(1'b1, ra, tg, 1'b1, acc);
      if (!acc) notrdy++;
      tg = tg + 1'b1;
    end
    chk("stream_in_ready", notrdy, 0);
    drain("stream_drain");

    // Random stalls on both sides
    sent = 0; cycles = 0; tg = '0;
    while ((sent < 10000 || sbq.size() != 0) && cycles < 60000) begin
      ra = {2'($urandom), 32'($urandom)};
      cyc((sent < 10000) ? 1'($urandom) : 1'b0, ra, tg, 1'($urandom), acc);
      if (acc) begin sent++; tg = tg + 1'b1; end
      cycles++;
    end
    chk("rand_sent", sent, 10000);
    chk("rand_empty", sbq.size(), 0);

    // Reset mid-flight
    for (int i = 0; i < 3; i++) cyc(1'b1, 34'(12345 + i), 4'(i + 3), 1'b0, acc);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_s", out_s, 0);
    chk("mrst_out_tag", out_tag, 0);
    chk("mrst_busy", busy, 0);
    @(negedge clk);
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (out_valid) nacc++;
      @(negedge clk);
    end
    chk("mrst_no_stale", nacc, 0);
    run_single("mrst_seven", 34'd7, 4'd9, 17'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
